// File: rtl/branch_redirect_ctrl_if.sv
// Branch redirect bus: mispredict capture inputs from commit/branch queue,
// flush/stall to the pipeline, valid/ready redirect to fetch, and statistics.
//   slave  : the redirect controller (consumes mispredict, drives flush/redirect)
//   master : the surrounding pipeline (drives mispredict/redirect_ready)
interface branch_redirect_ctrl_if #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ROB_IDX_BITS = 5,
    parameter int unsigned CNT_WIDTH    = 16
) ();
    logic                    mispredict;
    logic [XLEN-1:0]         mispredict_pc;
    logic [ROB_IDX_BITS-1:0] mispredict_rob;
    logic                    redirect_ready;
    logic                    flush;
    logic                    dispatch_stall;
    logic                    redirect_valid;
    logic [XLEN-1:0]         redirect_pc;
    logic [ROB_IDX_BITS-1:0] last_rob_idx;
    logic [CNT_WIDTH-1:0]    mispredict_count;

    modport slave (
        input  mispredict, mispredict_pc, mispredict_rob, redirect_ready,
        output flush, dispatch_stall, redirect_valid, redirect_pc, last_rob_idx,
               mispredict_count
    );

    modport master (
        output mispredict, mispredict_pc, mispredict_rob, redirect_ready,
        input  flush, dispatch_stall, redirect_valid, redirect_pc, last_rob_idx,
               mispredict_count
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller. On a mispredict seen while idle it captures the
// resolved target (word aligned) and ROB index, pulses flush for one cycle,
// idles DRAIN_CYCLES cycles, then holds a valid/ready redirect to fetch until
// accepted. Dispatch is stalled for the whole sequence.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : branch_redirect_ctrl_if.slave (mispredict in, flush/stall/redirect/stats out)
module branch_redirect_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ROB_IDX_BITS = 5,   // log2 of ROB entries
    parameter int unsigned DRAIN_CYCLES = 2,   // 0..255
    parameter int unsigned CNT_WIDTH    = 16
) (
    input logic                   clk,
    input logic                   rst,
    branch_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StFlush, StDrain, StRedirect} state_e;

    localparam int unsigned DrainLoadInt = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam logic [7:0]  DrainLoad    = 8'(DrainLoadInt);

    state_e                  state_q, state_d;
    logic [7:0]              drain_q, drain_d;
    logic [XLEN-1:0]         pc_q, pc_d;
    logic [ROB_IDX_BITS-1:0] rob_q, rob_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    flush_q, stall_q, valid_q;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        pc_d    = pc_q;
        rob_d   = rob_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.mispredict) begin
                    state_d = StFlush;
                    // Fetch addresses are word aligned; drop the low two bits.
                    pc_d    = bus.mispredict_pc & ~XLEN'(3);
                    rob_d   = bus.mispredict_rob;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFlush: begin
                if (DRAIN_CYCLES > 0) begin
                    state_d = StDrain;
                    drain_d = DrainLoad;
                end else begin
                    state_d = StRedirect;
                end
            end
            StDrain: begin
                // Loaded with DRAIN_CYCLES-1, so 0 marks the last drain cycle.
                if (drain_q == '0) begin
                    state_d = StRedirect;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StRedirect: begin
                if (bus.redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            drain_q <= '0;
            pc_q    <= '0;
            rob_q   <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            stall_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            pc_q    <= pc_d;
            rob_q   <= rob_d;
            cnt_q   <= cnt_d;
            flush_q <= (state_d == StFlush);
            stall_q <= (state_d != StIdle);
            valid_q <= (state_d == StRedirect);
        end
    end

    assign bus.flush            = flush_q;
    assign bus.dispatch_stall   = stall_q;
    assign bus.redirect_valid   = valid_q;
    assign bus.redirect_pc      = pc_q;
    assign bus.last_rob_idx     = rob_q;
    assign bus.mispredict_count = cnt_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two builds (DRAIN_CYCLES=2/CNT_WIDTH=16 and
// DRAIN_CYCLES=0/CNT_WIDTH=2) share one stimulus stream. A per-build model tracks
// cycles elapsed since an accepted mispredict and derives outputs from that age.
module tb_branch_redirect_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mis  = 1'b0;
    logic [31:0] mpc  = '0;
    logic [4:0]  mrob = '0;
    logic        rdy  = 1'b0;

    branch_redirect_ctrl_if #(.XLEN(32), .ROB_IDX_BITS(5), .CNT_WIDTH(16)) ia ();
    branch_redirect_ctrl_if #(.XLEN(32), .ROB_IDX_BITS(5), .CNT_WIDTH(2))  ib ();

    assign ia.mispredict     = mis;
    assign ia.mispredict_pc  = mpc;
    assign ia.mispredict_rob = mrob;
    assign ia.redirect_ready = rdy;
    assign ib.mispredict     = mis;
    assign ib.mispredict_pc  = mpc;
    assign ib.mispredict_rob = mrob;
    assign ib.redirect_ready = rdy;

    branch_redirect_ctrl #(.XLEN(32), .ROB_IDX_BITS(5), .DRAIN_CYCLES(2), .CNT_WIDTH(16))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    branch_redirect_ctrl #(.XLEN(32), .ROB_IDX_BITS(5), .DRAIN_CYCLES(0), .CNT_WIDTH(2))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    int checks = 0;
    int errors = 0;

    // Model: busy flag, age = cycles since the accepting edge (1 = flush cycle).
    bit          m_busy [2];
    int unsigned m_age  [2];
    logic [31:0] m_pc   [2];
    logic [4:0]  m_rob  [2];
    int unsigned m_cnt  [2];
    int unsigned m_drain[2] = '{2, 0};
    int unsigned m_cmax [2] = '{65535, 3};

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_age[i] = 0; m_pc[i] = '0; m_rob[i] = '0; m_cnt[i] = 0;
        end
    endfunction

    function automatic logic exp_flush(input int i);
        return m_busy[i] && (m_age[i] == 1);
    endfunction

    function automatic logic exp_valid(input int i);
        return m_busy[i] && (m_age[i] >= m_drain[i] + 2);
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!m_busy[i]) begin
                if (mis) begin
                    m_busy[i] = 1'b1;
                    m_age[i]  = 1;
                    m_pc[i]   = {mpc[31:2], 2'b00};
                    m_rob[i]  = mrob;
                    if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
                end
            end else if (exp_valid(i) && rdy) begin
                m_busy[i] = 1'b0;
            end else begin
                m_age[i]++;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a.flush"}, 32'(ia.flush), 32'(exp_flush(0)));
        chk({tag, ".a.stall"}, 32'(ia.dispatch_stall), 32'(m_busy[0]));
        chk({tag, ".a.valid"}, 32'(ia.redirect_valid), 32'(exp_valid(0)));
        chk({tag, ".a.pc"}, ia.redirect_pc, m_pc[0]);
        chk({tag, ".a.rob"}, 32'(ia.last_rob_idx), 32'(m_rob[0]));
        chk({tag, ".a.cnt"}, 32'(ia.mispredict_count), m_cnt[0]);
        chk({tag, ".a.excl"}, 32'(ia.flush & ia.redirect_valid), 32'd0);
        chk({tag, ".b.flush"}, 32'(ib.flush), 32'(exp_flush(1)));
        chk({tag, ".b.stall"}, 32'(ib.dispatch_stall), 32'(m_busy[1]));
        chk({tag, ".b.valid"}, 32'(ib.redirect_valid), 32'(exp_valid(1)));
        chk({tag, ".b.pc"}, ib.redirect_pc, m_pc[1]);
        chk({tag, ".b.rob"}, 32'(ib.last_rob_idx), 32'(m_rob[1]));
        chk({tag, ".b.cnt"}, 32'(ib.mispredict_count), m_cnt[1]);
        chk({tag, ".b.excl"}, 32'(ib.flush & ib.redirect_valid), 32'd0);
    endtask

    // Called at a negedge: drive inputs, let one edge pass, check at the next negedge.
    task automatic step(input logic m, input logic [31:0] pc, input logic [4:0] rob,
                        input logic r);
        mis = m; mpc = pc; mrob = rob; rdy = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all("step");
    endtask

    // Asynchronous assert away from any edge; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        mis = 1'b0; rdy = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_all(tag);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all({tag, ".rel"});
    endtask

    typedef struct {
        logic        m;
        logic [31:0] pc;
        logic [4:0]  rob;
        logic        r;
        logic        f;
        logic        s;
        logic        v;
        logic [31:0] epc;
        logic [4:0]  erob;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // Row k: inputs sampled at edge k, outputs expected in the cycle after it.
        tbl[0] = '{1'b1, 32'h0000_1236, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 5'd5, 16'd1};
        tbl[1] = '{1'b0, 32'h0,         5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 5'd5, 16'd1};
        tbl[2] = '{1'b0, 32'h0,         5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 5'd5, 16'd1};
        tbl[3] = '{1'b0, 32'h0,         5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 5'd5, 16'd1};
        tbl[4] = '{1'b0, 32'h0,         5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 5'd5, 16'd1};
        tbl[5] = '{1'b0, 32'h0,         5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 5'd5, 16'd1};

        // Reset held three cycles, then released.
        model_reset();
        repeat (3) @(negedge clk);
        check_all("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_all("rst_rel");

        // Basic sequence, table driven.
        for (int k = 0; k < 6; k++) begin
            step(tbl[k].m, tbl[k].pc, tbl[k].rob, tbl[k].r);
            chk($sformatf("tbl%0d.flush", k), 32'(ia.flush), 32'(tbl[k].f));
            chk($sformatf("tbl%0d.stall", k), 32'(ia.dispatch_stall), 32'(tbl[k].s));
            chk($sformatf("tbl%0d.valid", k), 32'(ia.redirect_valid), 32'(tbl[k].v));
            chk($sformatf("tbl%0d.pc", k), ia.redirect_pc, tbl[k].epc);
            chk($sformatf("tbl%0d.rob", k), 32'(ia.last_rob_idx), 32'(tbl[k].erob));
            chk($sformatf("tbl%0d.cnt", k), 32'(ia.mispredict_count), 32'(tbl[k].ecnt));
        end

        // Backpressure with stale mispredict pulses, then back-to-back accept.
        async_reset("rst_bp");
        step(1'b1, 32'h0000_4003, 5'd7, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 5'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            chk("bp.valid", 32'(ia.redirect_valid), 32'd1);
            chk("bp.pc", ia.redirect_pc, 32'h0000_4000);
            step(k[0] ? 1'b0 : 1'b1, 32'hdead_beef, 5'd9, 1'b0);
        end
        chk("bp.valid7", 32'(ia.redirect_valid), 32'd1);
        step(1'b0, 32'h0, 5'd0, 1'b1);
        chk("bp.stall_fall", 32'(ia.dispatch_stall), 32'd0);
        chk("bp.cnt", 32'(ia.mispredict_count), 32'd1);
        chk("bp.rob", 32'(ia.last_rob_idx), 32'd7);
        step(1'b1, 32'h8000_0000, 5'd12, 1'b0);
        chk("b2b.cnt", 32'(ia.mispredict_count), 32'd2);
        chk("b2b.pc", ia.redirect_pc, 32'h8000_0000);
        chk("b2b.rob", 32'(ia.last_rob_idx), 32'd12);
        chk("b2b.flush", 32'(ia.flush), 32'd1);
        for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 5'd0, 1'b1);

        // Async reset while draining, then while redirecting.
        step(1'b1, 32'h0000_0100, 5'd3, 1'b1);
        step(1'b0, 32'h0, 5'd0, 1'b1);
        chk("drain.stall", 32'(ia.dispatch_stall), 32'd1);
        async_reset("rst_drain");
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 5'd0, 1'b1);
        step(1'b1, 32'h0000_0200, 5'd4, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 5'd0, 1'b0);
        chk("redir.valid", 32'(ia.redirect_valid), 32'd1);
        async_reset("rst_redir");
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 5'd0, 1'b1);

        // Saturation: five full sequences; the 2-bit counter stops at 3.
        for (int n = 0; n < 5; n++) begin
            step(1'b1, $urandom, 5'(n), 1'b1);
            for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 5'd0, 1'b1);
        end
        chk("sat.b_cnt", 32'(ib.mispredict_count), 32'd3);
        chk("sat.a_cnt", 32'(ia.mispredict_count), 32'd5);

        // Random traffic against the model.
        async_reset("rst_rand");
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 2) == 0), $urandom, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
